// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: instruction-fetch front end of the pipelined MIPS core.
// Owns the architectural PC, issues one request at a time on the
// instruction-side SRAM-like bus, and hands {pc, inst} to decode through
// a valid/allowin handshake. Branch/jump redirects from execute take
// priority in every state.
// Optional feature (macro FETCH_ADEL_EN): misaligned-PC detection that
// suppresses the bus request and delivers an address-error marker
// (if_adel, if_badvaddr) to decode instead of an instruction.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
    parameter int          ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              resetn,
    output logic [ADDR_W-1:0] pc_to_adder,
    input  logic [ADDR_W-1:0] pc_plus4,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_target,
    output logic              inst_req,
    output logic [ADDR_W-1:0] inst_addr,
    input  logic              inst_addr_ok,
    input  logic              inst_data_ok,
    input  logic [31:0]       inst_rdata,
    output logic              if_valid,
    output logic [ADDR_W-1:0] if_pc,
    output logic [31:0]       if_inst,
`ifdef FETCH_ADEL_EN
    output logic              if_adel,
    output logic [ADDR_W-1:0] if_badvaddr,
`endif
    input  logic              id_allowin
);

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic              cancel;
    logic              misaligned;

`ifdef FETCH_ADEL_EN
    assign misaligned = (pc[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    // Bus and decode-facing outputs decoded from the registered state.
    // The request is gated by resetn so nothing is issued while reset is held.
    assign pc_to_adder = pc;
    assign inst_addr   = pc;
    assign inst_req    = resetn && (state == REQ) && !misaligned;
    assign if_valid    = (state == HOLD);

    // Fetch FSM: PC update, outstanding-request bookkeeping and decode latch.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= REQ;
            pc          <= RESET_PC;
            cancel      <= 1'b0;
            if_pc       <= '0;
            if_inst     <= '0;
`ifdef FETCH_ADEL_EN
            if_adel     <= 1'b0;
            if_badvaddr <= '0;
`endif
        end else if (redirect_valid) begin
            pc <= redirect_target;
            case (state)
                REQ: begin
                    // An accepted request belongs to the old PC; its data
                    // must be swallowed when it comes back.
                    if (inst_req && inst_addr_ok) begin
                        state  <= WAIT;
                        cancel <= 1'b1;
                    end else begin
                        state  <= REQ;
                    end
                end
                WAIT: begin
                    if (inst_data_ok) begin
                        state  <= REQ;
                        cancel <= 1'b0;
                    end else begin
                        cancel <= 1'b1;
                    end
                end
                default: begin
                    // Held instruction is discarded even if decode took it.
                    state <= REQ;
                end
            endcase
        end else begin
            case (state)
                REQ: begin
                    if (misaligned) begin
                        state   <= HOLD;
                        if_pc   <= pc;
                        if_inst <= '0;
`ifdef FETCH_ADEL_EN
                        if_adel     <= 1'b1;
                        if_badvaddr <= pc;
`endif
                    end else if (inst_addr_ok) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (inst_data_ok) begin
                        if (cancel) begin
                            cancel <= 1'b0;
                            state  <= REQ;
                        end else begin
                            if_inst <= inst_rdata;
                            if_pc   <= pc;
`ifdef FETCH_ADEL_EN
                            if_adel <= 1'b0;
`endif
                            state   <= HOLD;
                        end
                    end
                end
                default: begin
                    if (id_allowin) begin
                        pc    <= pc_plus4;
                        state <= REQ;
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Instruction-fetch front end of the pipelined MIPS core. Owns the architectural PC register.
- Drives the PC into the shared 32-bit PC+4 adder (b operand tied to 4) and takes back its sum as the sequential next PC.
- Issues one instruction request at a time to the instruction-side SRAM-like bus.
- Delivers {pc, inst} to decode through a valid/allowin handshake, and accepts branch/jump redirects from execute.

Parameters:
- RESET_PC, 32'hBFC0_0000, PC value loaded on reset.
- ADDR_W, 32, PC and address width. Only 32 is supported.

Ports:
- clk  in  1  core clock; all state changes on rising edge.
- resetn  in  1  asynchronous active-low reset.
- pc_to_adder  out  32  current PC, fed to the PC+4 adder "a" input.
- pc_plus4  in  32  adder result (pc_to_adder + 4), used combinationally.
- redirect_valid  in  1  one-cycle branch/jump taken pulse from execute.
- redirect_target  in  32  new PC, sampled when redirect_valid=1.
- inst_req  out  1  instruction request valid.
- inst_addr  out  32  request address, equal to the PC.
- inst_addr_ok  in  1  request accepted this cycle.
- inst_data_ok  in  1  read data returned this cycle.
- inst_rdata  in  32  returned instruction word.
- if_valid  out  1  fetched instruction available to decode.
- if_pc  out  32  PC of the delivered instruction.
- if_inst  out  32  delivered instruction word.
- id_allowin  in  1  decode accepts the instruction this cycle.

Behaviour:
- Reset (resetn=0, asynchronous):
  - pc=RESET_PC, state=REQ, inst_req=0 while resetn is low, if_valid=0.
  - if_pc=0, if_inst=0, cancel flag=0.
- First cycle after resetn deasserts: inst_req=1, inst_addr=RESET_PC.
- States and transitions:
  - REQ: inst_req=1, inst_addr=pc. On inst_addr_ok go to WAIT.
  - WAIT: inst_req=0. On inst_data_ok, latch if_inst=inst_rdata and if_pc=pc, then go to HOLD.
  - HOLD: if_valid=1. On id_allowin, pc<=pc_plus4 and go to REQ.
- At most one outstanding request. inst_data_ok outside WAIT is ignored.
- inst_addr is stable while inst_req=1 && !inst_addr_ok, except on a redirect (below).
- Redirect is highest priority in every state; pc<=redirect_target.
  - REQ without addr_ok in the same cycle: stay in REQ with the new address next cycle.
  - REQ with addr_ok in the same cycle: go to WAIT with cancel=1.
  - WAIT: set cancel=1. When data_ok arrives, drop the data, clear cancel, go to REQ. if_valid never rises for the dropped word.
  - WAIT with data_ok in the same cycle: drop the data, go to REQ.
  - HOLD: if_valid falls next cycle and the held instruction is discarded, even if id_allowin=1 in the same cycle. Go to REQ.
- Throughput: best case 3 cycles per instruction (REQ, WAIT, HOLD) with addr_ok and data_ok at their earliest.
- Latency: redirect to new-address request is 1 cycle.
- Arithmetic: next PC comes only from the adder. Wrap 32'hFFFF_FFFC -> 0 is inherited modulo 2^32.
- A redirect arriving while resetn=0 is ignored.

Optional Feature:
- Macro FETCH_ADEL_EN.
- Defined:
  - Extra outputs if_adel (1 bit) and if_badvaddr (32 bits).
  - If pc[1:0]!=0 on entering REQ, no bus request is issued. The unit goes directly to HOLD with if_adel=1, if_badvaddr=pc, if_inst=0.
  - Redirect and allowin rules are unchanged.
  - if_adel resets to 0.
- Undefined:
  - Ports absent. pc[1:0] is passed to the bus unchecked.

Test Plan:
- Reset release, addr_ok and data_ok at earliest: inst_addr=BFC00000, then BFC00004; if_valid with if_pc=BFC00000, if_inst=inst_rdata. No request while resetn=0.
- addr_ok withheld 3 cycles: inst_addr held at BFC00000 with inst_req=1 for 4 cycles; exactly one if_valid follows.
- id_allowin=0 for 5 cycles in HOLD: if_pc/if_inst stable, no new inst_req; pc advances only after allowin.
- Redirect to 80001000 while in WAIT: the returning data is dropped (no if_valid), next inst_addr=80001000.
- Redirect in the same cycle as HOLD && id_allowin: the held instruction is not counted as consumed; next inst_addr=redirect_target.
- FETCH_ADEL_EN with redirect to 80000002: no inst_req; if_valid=1, if_adel=1, if_badvaddr=80000002.
